// File: rtl/mux_n_to_1_stream.sv
// -----------------------------------------------------------------------------
// mux_n_to_1_stream
//
// Purpose:
//   N-channel streaming multiplexer with a registered output stage and a
//   valid/ready handshake on every channel and on the output. Channel choice
//   comes either from an external select (i_mode=0) or from a round-robin
//   arbiter over the valid channels (i_mode=1).
//
// Optional feature (compile-time macro MUX_BURST_LOCK_EN):
//   When defined, a round-robin grant is held on one channel for BURST_LEN
//   transfers (one FFT frame). When undefined, arbitration is re-evaluated
//   on every beat and no lock state exists.
//
// Ports:
//   i_clk      clock, all state on the rising edge
//   i_rst_n    asynchronous active-low reset
//   i_d        channel data, channel i at i_d[i*DATA_WIDTH +: DATA_WIDTH]
//   i_v        per-channel valid
//   o_r        per-channel ready (combinational, at most one bit high)
//   i_mode     0 = external select, 1 = round-robin
//   i_s        channel select, used when i_mode=0
//   o_y        registered output sample
//   o_y_valid  o_y holds a valid sample
//   i_y_ready  downstream accepts o_y
//   o_y_ch     channel index that produced o_y
// -----------------------------------------------------------------------------
module mux_n_to_1_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int SEL_W      = 2,
  parameter int BURST_LEN  = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_d,
  input  logic [NUM_CH-1:0]            i_v,
  output logic [NUM_CH-1:0]            o_r,
  input  logic                         i_mode,
  input  logic [SEL_W-1:0]             i_s,
  output logic [DATA_WIDTH-1:0]        o_y,
  output logic                         o_y_valid,
  input  logic                         i_y_ready,
  output logic [SEL_W-1:0]             o_y_ch
);

  // Output stage and round-robin pointer
  logic [DATA_WIDTH-1:0] r_y;
  logic                  r_y_valid;
  logic [SEL_W-1:0]      r_y_ch;
  logic [SEL_W-1:0]      r_ptr;

  // Arbitration / handshake wires
  logic                  w_accept;
  logic                  w_ext_ok;
  logic [SEL_W-1:0]      w_rr_sel;
  logic                  w_rr_hit;
  logic [SEL_W-1:0]      w_sel;
  logic                  w_sel_ok;
  logic [NUM_CH-1:0]     w_r;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_d_sel;
  logic                  w_locked;

  // The output register can take a new sample when empty or being drained.
  assign w_accept = !r_y_valid || i_y_ready;

  // An external select beyond the channel count selects nothing.
  assign w_ext_ok = ({1'b0, i_s} < (SEL_W+1)'(NUM_CH));

  // Round-robin scan: first valid channel starting just after the pointer.
  always_comb begin
    logic [SEL_W-1:0] v_idx;
    w_rr_sel = '0;
    w_rr_hit = 1'b0;
    v_idx    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      v_idx = SEL_W'((int'(r_ptr) + k) % NUM_CH);
      if (!w_rr_hit && i_v[v_idx]) begin
        w_rr_hit = 1'b1;
        w_rr_sel = v_idx;
      end else begin
        w_rr_hit = w_rr_hit;
      end
    end
  end

  // Channel selection: an active burst lock overrides both modes.
  always_comb begin
    w_sel    = '0;
    w_sel_ok = 1'b0;
    if (w_locked) begin
      w_sel    = w_locked_ch();
      w_sel_ok = 1'b1;
    end else if (!i_mode) begin
      w_sel    = i_s;
      w_sel_ok = w_ext_ok;
    end else begin
      w_sel    = w_rr_sel;
      w_sel_ok = w_rr_hit;
    end
  end

  // Ready is one-hot on the selected channel; it is forced low while reset
  // is asserted so upstream never sees a grant from a resetting mux.
  always_comb begin
    w_r = '0;
    if (w_accept && w_sel_ok && i_rst_n) begin
      w_r[w_sel] = 1'b1;
    end else begin
      w_r = '0;
    end
  end

  assign w_xfer  = |(w_r & i_v);
  assign w_d_sel = i_d[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];

  // Output register, channel tag and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
      r_y_ch    <= '0;
      r_ptr     <= SEL_W'(NUM_CH - 1);
    end else if (w_xfer) begin
      r_y       <= w_d_sel;
      r_y_valid <= 1'b1;
      r_y_ch    <= w_sel;
      r_ptr     <= w_sel;  // external-select transfers also move fairness
    end else if (w_accept) begin
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= r_y_valid;
    end
  end

`ifdef MUX_BURST_LOCK_EN
  localparam int          CNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_LOCK = 1'b1;

  logic [0:0]       r_state;
  logic [SEL_W-1:0] r_lch;
  logic [CNT_W-1:0] r_cnt;

  assign w_locked = (r_state == ST_LOCK);

  function automatic logic [SEL_W-1:0] w_locked_ch();
    return r_lch;
  endfunction

  // Burst lock: r_cnt counts beats already sent in the current burst.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_lch   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer && i_mode && (BURST_LEN > 1)) begin
            r_state <= ST_LOCK;
            r_lch   <= w_sel;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOCK: begin
          if (w_xfer) begin
            if (r_cnt == CNT_W'(BURST_LEN - 1)) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_state <= ST_LOCK;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
`else
  assign w_locked = 1'b0;

  function automatic logic [SEL_W-1:0] w_locked_ch();
    return '0;
  endfunction
`endif

  assign o_r       = w_r;
  assign o_y       = r_y;
  assign o_y_valid = r_y_valid;
  assign o_y_ch    = r_y_ch;

endmodule
